pkt_switch_nport: RTL and testbench

- Parametrised successor to the single-channel packet path: one ingress byte stream is routed to one of NUM_PORTS egress ports, each with its own FIFO.
- Routing is by header address, matched against per-port address registers programmed over the 16-bit configuration bus.
- Packets are admitted whole or dropped whole. Dropped packets are counted.
- Sits between the packet source and the per-port consumers. The configuration bus is shared with the existing conf master.

---
 rtl/pkt_switch_nport_if.sv | 32 +++
 rtl/pkt_switch_nport.sv | 208 ++++++++++++++++++++
 tb/tb_pkt_switch_nport.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pkt_switch_nport_if.sv
// Configuration bus plus ingress and per-port egress signals of pkt_switch_nport.
// The switch uses the slave view; the packet source / conf master uses the master view.
interface pkt_switch_nport_if #(
  parameter int DATA_W    = 8,
  parameter int NUM_PORTS = 4
);
  logic [15:0]                 conf_data_write;
  logic [15:0]                 conf_data_read;
  logic [3:0]                  conf_address;
  logic                        conf_read_write;
  logic                        conf_data_valid;
  logic [DATA_W-1:0]           package_in;
  logic                        package_in_start;
  logic                        package_in_valid;
  logic [NUM_PORTS*DATA_W-1:0] package_out;
  logic [NUM_PORTS-1:0]        package_out_start;
  logic [NUM_PORTS-1:0]        package_out_end;
  logic [NUM_PORTS-1:0]        read_data_valid;
  logic [NUM_PORTS-1:0]        package_ack;

  modport master (
    output conf_data_write, conf_address, conf_read_write, conf_data_valid,
    output package_in, package_in_start, package_in_valid, package_ack,
    input  conf_data_read, package_out, package_out_start, package_out_end, read_data_valid
  );

  modport slave (
    input  conf_data_write, conf_address, conf_read_write, conf_data_valid,
    input  package_in, package_in_start, package_in_valid, package_ack,
    output conf_data_read, package_out, package_out_start, package_out_end, read_data_valid
  );
endinterface

// File: rtl/pkt_switch_nport.sv
// Routes one ingress packet stream to NUM_PORTS egress FIFOs by header address.
// Whole packets are admitted or dropped at the length byte; drops are counted.
module pkt_switch_nport #(
  parameter int DATA_W     = 8,
  parameter int NUM_PORTS  = 4,
  parameter int FIFO_DEPTH = 16
) (
  input logic               clk,
  input logic               rst,
  pkt_switch_nport_if.slave bus
);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int PORT_W  = $clog2(NUM_PORTS);
  localparam int ENTRY_W = DATA_W + 2;

  typedef enum logic [1:0] {S_IDLE, S_LEN, S_PAYLOAD, S_DROP} state_t;

  state_t                  state_q, state_d;
  logic [DATA_W-1:0]       header_q, header_d;
  logic [DATA_W-1:0]       remaining_q, remaining_d;
  logic [PORT_W-1:0]       dest_q, dest_d, hit_port;
  logic                    first_q, first_d;
  logic                    hit, fits, wr_en, drop_inc;
  logic [ENTRY_W-1:0]      wr_entry;
  logic [DATA_W-1:0]       match_q [NUM_PORTS];
  logic                    enable_q;
  logic [15:0]             drop_cnt_q, status, rd_mux, conf_rd_q;
  logic                    conf_wr, conf_rd;
  logic [CNT_W-1:0]        fifo_cnt [NUM_PORTS];
  logic [CNT_W-1:0]        free_space;
  logic [ENTRY_W-1:0]      head [NUM_PORTS];
  logic [NUM_PORTS-1:0]    nonempty, full;
  logic [NUM_PORTS*DATA_W-1:0] out_data;
  logic [NUM_PORTS-1:0]    out_sop, out_eop;

  assign conf_wr = bus.conf_data_valid && !bus.conf_read_write;
  assign conf_rd = bus.conf_data_valid && bus.conf_read_write;

  always_comb begin
    status = '0;
    status[NUM_PORTS-1:0] = nonempty;
    status[8 +: NUM_PORTS] = full;
  end

  always_comb begin
    rd_mux = '0;
    if (bus.conf_address < 4'(NUM_PORTS)) begin
      rd_mux[DATA_W-1:0] = match_q[bus.conf_address[PORT_W-1:0]];
    end else begin
      case (bus.conf_address)
        4'h8:    rd_mux[0] = enable_q;
        4'h9:    rd_mux = drop_cnt_q;
        4'hA:    rd_mux = status;
        default: rd_mux = '0;
      endcase
    end
  end

  // A clear write beats a simultaneous drop increment.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NUM_PORTS; k++) match_q[k] <= DATA_W'(k);
      enable_q   <= 1'b1;
      drop_cnt_q <= '0;
      conf_rd_q  <= '0;
    end else begin
      if (conf_wr && bus.conf_address < 4'(NUM_PORTS))
        match_q[bus.conf_address[PORT_W-1:0]] <= bus.conf_data_write[DATA_W-1:0];
      if (conf_wr && bus.conf_address == 4'h8) enable_q <= bus.conf_data_write[0];
      if (conf_wr && bus.conf_address == 4'h9) drop_cnt_q <= '0;
      else if (drop_inc && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
      if (conf_rd) conf_rd_q <= rd_mux;
    end
  end

  assign bus.conf_data_read = conf_rd_q;

  // Descending scan so the lowest matching port wins.
  always_comb begin
    hit      = 1'b0;
    hit_port = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (match_q[k] == header_q) begin
        hit      = 1'b1;
        hit_port = PORT_W'(k);
      end
    end
  end

  assign free_space = CNT_W'(FIFO_DEPTH) - fifo_cnt[hit_port];
  assign fits       = 32'(bus.package_in) <= 32'(free_space);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      header_q    <= '0;
      remaining_q <= '0;
      dest_q      <= '0;
      first_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      header_q    <= header_d;
      remaining_q <= remaining_d;
      dest_q      <= dest_d;
      first_q     <= first_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    header_d    = header_q;
    remaining_d = remaining_q;
    dest_d      = dest_q;
    first_d     = first_q;
    wr_en       = 1'b0;
    wr_entry    = '0;
    drop_inc    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.package_in_valid && bus.package_in_start) begin
          header_d = bus.package_in;
          state_d  = S_LEN;
        end
      end
      S_LEN: begin
        if (bus.package_in_valid) begin
          remaining_d = bus.package_in;
          if (enable_q && hit && bus.package_in != '0 && fits) begin
            dest_d  = hit_port;
            first_d = 1'b1;
            state_d = S_PAYLOAD;
          end else begin
            drop_inc = 1'b1;
            state_d  = (bus.package_in == '0) ? S_IDLE : S_DROP;
          end
        end
      end
      S_PAYLOAD: begin
        if (bus.package_in_valid) begin
          wr_en       = 1'b1;
          wr_entry    = {first_q, remaining_q == DATA_W'(1), bus.package_in};
          first_d     = 1'b0;
          remaining_d = remaining_q - DATA_W'(1);
          if (remaining_q == DATA_W'(1)) state_d = S_IDLE;
        end
      end
      S_DROP: begin
        if (bus.package_in_valid) begin
          remaining_d = remaining_q - DATA_W'(1);
          if (remaining_q == DATA_W'(1)) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Space was reserved at the length decision, so a push never finds a full FIFO.
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   cnt;
    logic               push, pop;

    assign push = wr_en && (dest_q == PORT_W'(g));
    assign pop  = (cnt != '0) && bus.package_ack[g];

    always_ff @(posedge clk) begin
      if (rst && push) mem[wr_ptr] <= wr_entry;
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !pop)      cnt <= cnt + CNT_W'(1);
        else if (pop && !push) cnt <= cnt - CNT_W'(1);
      end
    end

    assign fifo_cnt[g] = cnt;
    assign head[g]     = mem[rd_ptr];
    assign nonempty[g] = (cnt != '0);
    assign full[g]     = (cnt == CNT_W'(FIFO_DEPTH));
  end

  always_comb begin
    out_data = '0;
    out_sop  = '0;
    out_eop  = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (nonempty[k]) begin
        out_data[k*DATA_W +: DATA_W] = head[k][DATA_W-1:0];
        out_sop[k] = head[k][DATA_W+1];
        out_eop[k] = head[k][DATA_W];
      end
    end
  end

  assign bus.package_out       = out_data;
  assign bus.package_out_start = out_sop;
  assign bus.package_out_end   = out_eop;
  assign bus.read_data_valid   = nonempty;
endmodule

// File: tb/tb_pkt_switch_nport.sv
// Scoreboard bench for pkt_switch_nport: a packet-level model predicts admission
// and egress bytes; a negedge monitor checks every byte a consumer accepts.
`timescale 1ns/1ps
module tb_pkt_switch_nport;
  localparam int DW    = 8;
  localparam int NP    = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pkt_switch_nport_if #(.DATA_W(DW), .NUM_PORTS(NP)) bus ();

  pkt_switch_nport #(.DATA_W(DW), .NUM_PORTS(NP), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int         n_compared   = 0;
  int         n_mismatched = 0;
  logic [9:0] exp_q [NP][$];
  int         occ [NP];
  bit         pop_pend [NP];
  int         push_port = -1;
  logic [7:0] mm [NP];
  bit         enable_m;
  int         drop_m;
  bit         ack_mode = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_compared++;
    if (act !== req) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic logic [15:0] modelStatus();
    logic [15:0] s;
    s = '0;
    for (int k = 0; k < NP; k++) begin
      if (occ[k] > 0) s[k] = 1'b1;
      if (occ[k] == DEPTH) s[8+k] = 1'b1;
    end
    return s;
  endfunction

  function automatic int bytesOwed();
    int n;
    n = 0;
    for (int k = 0; k < NP; k++) n += exp_q[k].size();
    return n;
  endfunction

  // Occupancy bookkeeping: accepted pops and admitted pushes land on the clock edge.
  always @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NP; k++) begin
        occ[k] = 0;
        pop_pend[k] = 1'b0;
        exp_q[k].delete();
      end
      push_port = -1;
    end else begin
      for (int k = 0; k < NP; k++) begin
        if (pop_pend[k]) begin
          occ[k]--;
          pop_pend[k] = 1'b0;
        end
      end
      if (push_port >= 0) begin
        occ[push_port]++;
        push_port = -1;
      end
    end
  end

  always @(negedge clk) begin
    logic [9:0] got, want;
    if (rst) begin
      for (int k = 0; k < NP; k++) begin
        if (bus.read_data_valid[k] && bus.package_ack[k]) begin
          got = {bus.package_out_start[k], bus.package_out_end[k], bus.package_out[k*DW +: DW]};
          pop_pend[k] = 1'b1;
          if (exp_q[k].size() == 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL port%0d_extra: got %h, required no byte", k, got);
          end else begin
            want = exp_q[k].pop_front();
            checkOutput($sformatf("port%0d_byte", k), 32'(got), 32'(want));
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (ack_mode) bus.package_ack = 4'($urandom);
  endtask

  task automatic resetModelRegs();
    for (int k = 0; k < NP; k++) mm[k] = 8'(k);
    enable_m = 1'b1;
    drop_m   = 0;
  endtask

  task automatic writeReg(input logic [3:0] addr, input logic [15:0] data);
    bus.conf_address    = addr;
    bus.conf_data_write = data;
    bus.conf_read_write = 1'b0;
    bus.conf_data_valid = 1'b1;
    tick();
    bus.conf_data_valid = 1'b0;
    if (addr < 4'(NP)) mm[addr] = data[7:0];
    if (addr == 4'h8) enable_m = data[0];
    if (addr == 4'h9) drop_m = 0;
  endtask

  task automatic readReg(input string name, input logic [3:0] addr, input logic [15:0] req);
    bus.conf_address    = addr;
    bus.conf_read_write = 1'b1;
    bus.conf_data_valid = 1'b1;
    tick();
    bus.conf_data_valid = 1'b0;
    checkOutput(name, 32'(bus.conf_data_read), 32'(req));
  endtask

  task automatic sendByte(input logic [7:0] d, input logic s, input bit gaps);
    bus.package_in       = d;
    bus.package_in_start = s;
    bus.package_in_valid = 1'b1;
    tick();
    bus.package_in_valid = 1'b0;
    bus.package_in_start = 1'b0;
    bus.package_in       = 8'($urandom);
    if (gaps) repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic midReset();
    rst = 1'b0;
    bus.package_in_valid = 1'b0;
    tick();
    checkOutput("rst_mid_valid", 32'(bus.read_data_valid), 32'h0);
    checkOutput("rst_mid_out", 32'(bus.package_out), 32'h0);
    rst = 1'b1;
    resetModelRegs();
    tick();
  endtask

  // Model decides admission from routing table, enable and free space at the length byte.
  task automatic sendPacket(input logic [7:0] hdr, input int len, input bit gaps,
                            input bit noise, input int abort_after);
    int dst;
    bit acc;
    logic [7:0] b;
    sendByte(hdr, 1'b1, gaps);
    dst = -1;
    for (int k = NP - 1; k >= 0; k--) if (mm[k] == hdr) dst = k;
    acc = 1'b0;
    if (enable_m && dst >= 0 && len != 0) acc = (DEPTH - occ[dst]) >= len;
    if (!acc && drop_m < 65535) drop_m++;
    sendByte(8'(len), 1'b0, gaps);
    for (int i = 0; i < len; i++) begin
      if (i == abort_after) begin
        midReset();
        return;
      end
      b = 8'($urandom);
      if (acc) begin
        exp_q[dst].push_back({i == 0, i == len - 1, b});
        push_port = dst;
      end
      sendByte(b, noise && i[0], gaps);
    end
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (bytesOwed() > 0 && n < 500) begin
      tick();
      n++;
    end
    n_compared++;
    if (bytesOwed() > 0) begin
      n_mismatched++;
      $display("[TB] FAIL drain: got %0d bytes still owed after %0d cycles, required 0", bytesOwed(), n);
    end
    repeat (3) tick();
  endtask

  task automatic applyStimulus();
    logic [7:0] hdr;
    bus.conf_data_write = '0;
    bus.conf_address = '0;
    bus.conf_read_write = 1'b0;
    bus.conf_data_valid = 1'b0;
    bus.package_in = '0;
    bus.package_in_start = 1'b0;
    bus.package_in_valid = 1'b0;
    bus.package_ack = '0;
    rst = 1'b0;
    repeat (3) tick();
    checkOutput("reset_valid", 32'(bus.read_data_valid), 32'h0);
    checkOutput("reset_out", 32'(bus.package_out), 32'h0);
    checkOutput("reset_sop_eop", 32'({bus.package_out_start, bus.package_out_end}), 32'h0);
    checkOutput("reset_conf_read", 32'(bus.conf_data_read), 32'h0);
    rst = 1'b1;
    resetModelRegs();
    tick();
    readReg("drop_cnt_reset", 4'h9, 16'h0000);
    readReg("ctrl_reset", 4'h8, 16'h0001);
    readReg("match2_reset", 4'h2, 16'h0002);
    readReg("status_reset", 4'hA, 16'h0000);

    $display("[TB] default routing");
    bus.package_ack = '1;
    sendPacket(8'h02, 3, 1'b0, 1'b0, -1);
    waitDrain();
    readReg("drop_cnt_default", 4'h9, 16'(drop_m));

    $display("[TB] reprogram MATCH[1]");
    writeReg(4'h1, 16'h0055);
    readReg("match1_write", 4'h1, 16'h0055);
    sendPacket(8'h55, 2, 1'b1, 1'b0, -1);
    sendPacket(8'h01, 1, 1'b0, 1'b0, -1);
    waitDrain();
    readReg("drop_cnt_nomatch", 4'h9, 16'(drop_m));
    writeReg(4'h9, 16'hFFFF);
    readReg("drop_cnt_clear", 4'h9, 16'(drop_m));

    $display("[TB] backpressure on port 0");
    bus.package_ack = 4'b1110;
    sendPacket(8'h00, 10, 1'b1, 1'b0, -1);
    sendPacket(8'h00, 8, 1'b0, 1'b0, -1);
    sendPacket(8'h00, 6, 1'b1, 1'b0, -1);
    readReg("status_full", 4'hA, modelStatus());
    readReg("drop_cnt_space", 4'h9, 16'(drop_m));
    bus.package_ack = '1;
    waitDrain();
    readReg("status_drained", 4'hA, modelStatus());
    writeReg(4'h9, 16'h0000);

    $display("[TB] edge cases");
    sendPacket(8'h03, 0, 1'b0, 1'b0, -1);
    writeReg(4'h8, 16'h0000);
    sendPacket(8'h03, 2, 1'b0, 1'b0, -1);
    writeReg(4'h8, 16'h0001);
    sendPacket(8'h03, 4, 1'b0, 1'b1, -1);
    sendPacket(8'h77, 3, 1'b0, 1'b0, -1);
    writeReg(4'hC, 16'h0000);
    waitDrain();
    readReg("drop_cnt_edges", 4'h9, 16'(drop_m));
    readReg("ctrl_after_unmapped_wr", 4'h8, 16'h0001);
    readReg("unmapped_read", 4'hB, 16'h0000);

    $display("[TB] random traffic with random acks");
    ack_mode = 1'b1;
    for (int p = 0; p < 30; p++) begin
      hdr = ($urandom_range(0, 4) < 4) ? mm[$urandom_range(0, NP - 1)] : 8'($urandom);
      sendPacket(hdr, $urandom_range(0, 20), 1'b1, 1'($urandom_range(0, 1)), -1);
      if (p % 6 == 5) readReg("status_random", 4'hA, modelStatus());
    end
    ack_mode = 1'b0;
    bus.package_ack = '1;
    waitDrain();
    readReg("drop_cnt_random", 4'h9, 16'(drop_m));

    $display("[TB] back-to-back streaming");
    for (int p = 0; p < 20; p++) begin
      sendPacket(mm[$urandom_range(0, NP - 1)], $urandom_range(1, 12), 1'b0, 1'b0, -1);
      if (p % 5 == 4) readReg("status_stream", 4'hA, modelStatus());
    end
    waitDrain();

    $display("[TB] mid-packet reset");
    sendPacket(8'h02, 5, 1'b0, 1'b0, 2);
    readReg("status_after_rst", 4'hA, 16'h0000);
    readReg("match1_after_rst", 4'h1, 16'h0001);
    sendPacket(8'h01, 3, 1'b0, 1'b0, -1);
    waitDrain();
    readReg("drop_cnt_after_rst", 4'h9, 16'(drop_m));
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyStimulus();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
